rf_writeback_ctrl: RTL and testbench

RF_WRITEBACK_CTRL -- requirements
Module: rf_writeback_ctrl

---
 rtl/rf_wb_pkg.sv | 11 +
 rtl/rf_wb_fifo.sv | 50 +++++
 rtl/rf_writeback_ctrl.sv | 105 ++++++++++
 tb/tb_rf_writeback_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - shared widths and queue entry type for the register-file writeback controller
package rf_wb_pkg;
   localparam int XLEN      = 64;
   localparam int REG_IDX_W = 5;
   localparam int NUM_REGS  = 32;

   typedef struct packed {
      logic [REG_IDX_W-1:0] rd;
      logic [XLEN-1:0]      data;
   } wb_entry_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// rtl/rf_wb_fifo.sv - DEPTH-entry writeback queue; ready is derived from the registered count only
module rf_wb_fifo
   import rf_wb_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_valid,
   input  wb_entry_t     push_entry,
   input  logic          pop,
   output logic          not_empty,
   output wb_entry_t     head,
   output logic [CW-1:0] count
);

   wb_entry_t      mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic           push;
   logic           do_pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A pop in the same cycle does not open room for a push; ready stays count-based.
   assign push      = push_valid && (count < CW'(DEPTH));
   assign not_empty = (count != '0);
   assign do_pop    = pop && not_empty;
   assign head      = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= bump(wr_ptr);
         end
         if (do_pop) rd_ptr <= bump(rd_ptr);
         count <= count + CW'(push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// rtl/rf_writeback_ctrl.sv - arbitrates ALU and load results onto one RF write port, tracks pending regs
// Optional macro RF_WB_BYPASS_EN adds a two-read-port bypass from the registered write port.
module rf_writeback_ctrl
   import rf_wb_pkg::wb_entry_t;
   import rf_wb_pkg::REG_IDX_W;
   import rf_wb_pkg::NUM_REGS;
#(
   parameter int XLEN  = 64,
   parameter int DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 alu_valid,
   output logic                 alu_ready,
   input  logic [REG_IDX_W-1:0] alu_rd,
   input  logic [XLEN-1:0]      alu_data,
   input  logic                 ld_valid,
   output logic                 ld_ready,
   input  logic [REG_IDX_W-1:0] ld_rd,
   input  logic [XLEN-1:0]      ld_data,
   input  logic                 alloc_valid,
   input  logic [REG_IDX_W-1:0] alloc_rd,
   output logic                 RegWrite,
   output logic [REG_IDX_W-1:0] RD,
   output logic [XLEN-1:0]      WriteData,
   output logic [NUM_REGS-1:0]  busy
`ifdef RF_WB_BYPASS_EN
   ,
   input  logic [REG_IDX_W-1:0] rs1,
   input  logic [REG_IDX_W-1:0] rs2,
   output logic                 byp1_hit,
   output logic                 byp2_hit,
   output logic [XLEN-1:0]      byp1_data,
   output logic [XLEN-1:0]      byp2_data
`endif
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = $bits(wb_entry_t) - REG_IDX_W;

   wb_entry_t          alu_in, ld_in, alu_head, ld_head, win;
   logic [CW-1:0]      alu_count, ld_count;
   logic               alu_ne, ld_ne, grant_alu, grant_ld, grant, prio_ld;
   logic [NUM_REGS-1:0] busy_next;

   assign alu_in = '{rd: alu_rd, data: EW'(alu_data)};
   assign ld_in  = '{rd: ld_rd,  data: EW'(ld_data)};

   rf_wb_fifo #(.DEPTH(DEPTH)) u_alu_q (
      .clk(clk), .reset(reset), .push_valid(alu_valid), .push_entry(alu_in),
      .pop(grant_alu), .not_empty(alu_ne), .head(alu_head), .count(alu_count)
   );

   rf_wb_fifo #(.DEPTH(DEPTH)) u_ld_q (
      .clk(clk), .reset(reset), .push_valid(ld_valid), .push_entry(ld_in),
      .pop(grant_ld), .not_empty(ld_ne), .head(ld_head), .count(ld_count)
   );

   assign alu_ready = (alu_count < CW'(DEPTH));
   assign ld_ready  = (ld_count < CW'(DEPTH));

   // prio_ld names the queue that wins the next contended cycle.
   always_comb begin
      grant_ld  = 1'b0;
      grant_alu = 1'b0;
      if (ld_ne && (!alu_ne || prio_ld)) grant_ld = 1'b1;
      else if (alu_ne)                   grant_alu = 1'b1;
      grant = grant_ld || grant_alu;
      win   = grant_ld ? ld_head : alu_head;
   end

   // A set wins over a clear of the same register.
   always_comb begin
      busy_next = busy;
      if (RegWrite) busy_next[RD] = 1'b0;
      if (alloc_valid) busy_next[alloc_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         RegWrite  <= 1'b0;
         RD        <= '0;
         WriteData <= '0;
         prio_ld   <= 1'b1;
         busy      <= '0;
      end else begin
         RegWrite <= grant && (win.rd != '0);
         if (grant && (win.rd != '0)) begin
            RD        <= win.rd;
            WriteData <= win.data[XLEN-1:0];
         end
         if (grant) prio_ld <= grant_alu;
         busy <= busy_next;
      end
   end

`ifdef RF_WB_BYPASS_EN
   assign byp1_hit  = RegWrite && (RD == rs1) && (rs1 != '0);
   assign byp2_hit  = RegWrite && (RD == rs2) && (rs2 != '0);
   assign byp1_data = byp1_hit ? WriteData : '0;
   assign byp2_data = byp2_hit ? WriteData : '0;
`endif

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// tb/tb_rf_writeback_ctrl.sv - scoreboard bench for rf_writeback_ctrl; load data carries bit 63 as source tag
module tb_rf_writeback_ctrl;
   import rf_wb_pkg::*;

   localparam logic [63:0] LD = 64'h8000_0000_0000_0000;

   logic        clk, reset;
   logic        alu_valid, alu_ready, ld_valid, ld_ready, alloc_valid, RegWrite;
   logic [4:0]  alu_rd, ld_rd, alloc_rd, RD;
   logic [63:0] alu_data, ld_data, WriteData;
   logic [31:0] busy;
`ifdef RF_WB_BYPASS_EN
   logic [4:0]  rs1, rs2;
   logic        byp1_hit, byp2_hit;
   logic [63:0] byp1_data, byp2_data;
`endif

   int checks = 0;
   int errors = 0;
   wb_entry_t exp_alu[$];
   wb_entry_t exp_ld[$];
   bit        seq[$];
   logic [31:0] exp_busy = '0;
   logic [31:0] snap;
   logic        prev_rw = 1'b0;
   logic [4:0]  prev_rd = '0;
   logic        saw_full;

   rf_writeback_ctrl #(.XLEN(64), .DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
      .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData), .busy(busy)
`ifdef RF_WB_BYPASS_EN
      , .rs1(rs1), .rs2(rs2), .byp1_hit(byp1_hit), .byp2_hit(byp2_hit),
      .byp1_data(byp1_data), .byp2_data(byp2_data)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic put_alu(input logic [4:0] rd, input logic [63:0] d);
      alu_valid = 1'b1; alu_rd = rd; alu_data = d;
      if (rd != 0) exp_alu.push_back('{rd: rd, data: d});
   endtask

   task automatic put_ld(input logic [4:0] rd, input logic [63:0] d);
      ld_valid = 1'b1; ld_rd = rd; ld_data = d;
      if (rd != 0) exp_ld.push_back('{rd: rd, data: d});
   endtask

   // Advance one clock, then check busy against the model and retire any write.
   task automatic cycle();
      wb_entry_t e;
      @(negedge clk);
      if (reset) exp_busy = '0;
      else begin
         if (prev_rw) exp_busy[prev_rd] = 1'b0;
         if (alloc_valid && alloc_rd != 0) exp_busy[alloc_rd] = 1'b1;
      end
      chk("busy_model", busy, exp_busy);
      prev_rw = RegWrite;
      prev_rd = RD;
      if (RegWrite) begin
         if (WriteData[63]) begin
            seq.push_back(1'b1);
            if (exp_ld.size() == 0) chk("ld_spurious_write", 1, 0);
            else begin
               e = exp_ld.pop_front();
               chk("ld_rd", RD, e.rd);
               chk("ld_data", WriteData, e.data);
            end
         end else begin
            seq.push_back(1'b0);
            if (exp_alu.size() == 0) chk("alu_spurious_write", 1, 0);
            else begin
               e = exp_alu.pop_front();
               chk("alu_rd", RD, e.rd);
               chk("alu_data", WriteData, e.data);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; alu_valid = 0; ld_valid = 0; alloc_valid = 0;
      alu_rd = 0; ld_rd = 0; alloc_rd = 0; alu_data = 0; ld_data = 0;
`ifdef RF_WB_BYPASS_EN
      rs1 = 0; rs2 = 0;
`endif
      repeat (2) cycle();
      reset = 1'b0;
      cycle();
      chk("rst_regwrite", RegWrite, 0);
      chk("rst_rd", RD, 0);
      chk("rst_wdata", WriteData, 0);
      chk("rst_busy", busy, 0);
      chk("rst_alu_ready", alu_ready, 1);
      chk("rst_ld_ready", ld_ready, 1);

      // single ALU push: write appears in the cycle after the second edge
      put_alu(5, 64'h1234);
      cycle();
      alu_valid = 0;
      chk("lat_k", RegWrite, 0);
      cycle();
      chk("lat_k1_rw", RegWrite, 1);
      chk("lat_k1_rd", RD, 5);
      chk("lat_k1_data", WriteData, 64'h1234);
      cycle();
      chk("lat_one_pulse", RegWrite, 0);

      // both sources push every cycle for 8 cycles
      seq.delete();
      saw_full = 0;
      for (int i = 0; i < 8; i++) begin
         alu_valid = 0; ld_valid = 0;
         if (alu_ready) put_alu(5'(1 + i), 64'h100 + 64'(i)); else saw_full = 1;
         if (ld_ready) put_ld(5'(11 + i), LD | (64'h200 + 64'(i))); else saw_full = 1;
         cycle();
      end
      alu_valid = 0; ld_valid = 0;
      repeat (12) cycle();
      chk("rr_ready_dropped", saw_full, 1);
      chk("rr_enough_writes", seq.size() >= 6, 1);
      for (int i = 0; i < 6 && i < seq.size(); i++)
         chk($sformatf("rr_order_%0d", i), seq[i], (i % 2 == 0));
      chk("rr_alu_drained", exp_alu.size(), 0);
      chk("rr_ld_drained", exp_ld.size(), 0);

      // busy set by alloc, cleared one cycle after the write pulse
      alloc_valid = 1; alloc_rd = 7;
      cycle();
      chk("busy7_set", busy[7], 1);
      alloc_valid = 0;
      put_ld(7, LD | 64'h77);
      cycle();
      ld_valid = 0;
      chk("busy7_accept", busy[7], 1);
      cycle();
      chk("busy7_wr_rw", RegWrite, 1);
      chk("busy7_wr_rd", RD, 7);
      chk("busy7_during_wr", busy[7], 1);
      cycle();
      chk("busy7_cleared", busy[7], 0);
      alloc_valid = 1; alloc_rd = 7;
      cycle();
      alloc_valid = 0;
      put_ld(7, LD | 64'h78);
      cycle();
      ld_valid = 0;
      cycle();
      chk("busy7_wr2_rw", RegWrite, 1);
      alloc_valid = 1; alloc_rd = 7;
      cycle();
      alloc_valid = 0;
      chk("busy7_set_wins", busy[7], 1);
      cycle();
      chk("busy7_stays", busy[7], 1);
      alloc_valid = 1; alloc_rd = 0;
      cycle();
      alloc_valid = 0;
      chk("busy0_const", busy[0], 0);

      // rd==0 entry is consumed silently; next entry writes one cycle later
      snap = busy;
      put_alu(0, 64'hFFFF);
      cycle();
      chk("rd0_k", RegWrite, 0);
      put_alu(3, 64'h33);
      cycle();
      alu_valid = 0;
      chk("rd0_no_write", RegWrite, 0);
      chk("rd0_busy", busy, snap);
      cycle();
      chk("rd0_next_rw", RegWrite, 1);
      chk("rd0_next_rd", RD, 3);
      cycle();

`ifdef RF_WB_BYPASS_EN
      rs1 = 9; rs2 = 0;
      put_alu(9, 64'hABCD);
      cycle();
      alu_valid = 0;
      cycle();
      chk("byp_rw", RegWrite, 1);
      chk("byp1_hit", byp1_hit, 1);
      chk("byp1_data", byp1_data, 64'hABCD);
      chk("byp2_miss", byp2_hit, 0);
      rs1 = 0;
      #1;
      chk("byp1_rs0_hit", byp1_hit, 0);
      chk("byp1_rs0_data", byp1_data, 0);
      cycle();
`endif

      // reset in the middle of draining full queues
      alloc_valid = 1; alloc_rd = 9;
      for (int i = 0; i < 3; i++) begin
         alu_valid = 0; ld_valid = 0;
         if (alu_ready) put_alu(5'(20 + i), 64'h300 + 64'(i));
         if (ld_ready) put_ld(5'(24 + i), LD | (64'h400 + 64'(i)));
         cycle();
         alloc_valid = 0;
      end
      alu_valid = 0; ld_valid = 0;
      cycle();
      reset = 1;
      exp_alu.delete();
      exp_ld.delete();
      cycle();
      chk("mid_rst_rw", RegWrite, 0);
      reset = 0;
      cycle();
      chk("post_rst_alu_ready", alu_ready, 1);
      chk("post_rst_ld_ready", ld_ready, 1);
      chk("post_rst_busy", busy, 0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("post_rst_no_write_%0d", i), RegWrite, 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
